// File: rtl/fnd_scan_driver_if.sv
// Digit/segment bundle between the BCD splitter (master) and the FND scan driver (slave).
// Carries the four BCD digits with dp/blank controls downstream, and the FND drive lines back out.
// Pure wiring, no latency; there is no backpressure on either side.
interface fnd_scan_driver_if;
  logic [3:0] i_digit1;
  logic [3:0] i_digit10;
  logic [3:0] i_digit100;
  logic [3:0] i_digit1000;
  logic [3:0] i_dp;
  logic       i_blank_en;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_font;
  logic       o_frame_tick;

  modport master (
    output i_digit1, i_digit10, i_digit100, i_digit1000, i_dp, i_blank_en,
    input  o_fnd_com, o_fnd_font, o_frame_tick
  );

  modport slave (
    input  i_digit1, i_digit10, i_digit100, i_digit1000, i_dp, i_blank_en,
    output o_fnd_com, o_fnd_font, o_frame_tick
  );
endinterface

// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode FND scanner: latches digits once per frame, decodes to active-low segments.
// Outputs registered one cycle behind scan state; new digits reach slot 0 BLANK_CYC+1 cycles after capture.
// No backpressure: inputs are sampled only at the frame boundary and ignored otherwise.
module fnd_scan_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  fnd_scan_driver_if.slave  bus
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] sh_dig;
  logic [3:0]      sh_dp;
  logic            sh_blank_en;

  logic            cnt_wrap;
  logic            load;

  assign cnt_wrap = (cnt == CNT_LAST);
  assign load     = cnt_wrap && (idx == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt         <= '0;
      idx         <= 2'd0;
      sh_dig      <= '0;
      sh_dp       <= 4'd0;
      sh_blank_en <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) begin
        idx <= idx + 2'd1;
      end
      // Whole frame is captured at once so a scan never mixes old and new digits.
      if (load) begin
        sh_dig[0]   <= bus.i_digit1;
        sh_dig[1]   <= bus.i_digit10;
        sh_dig[2]   <= bus.i_digit100;
        sh_dig[3]   <= bus.i_digit1000;
        sh_dp       <= bus.i_dp;
        sh_blank_en <= bus.i_blank_en;
      end
    end
  end

  logic [3:0] cur_dig;
  logic       blank3, blank2, blank1;
  logic       cur_blank;
  logic [6:0] seg;
  logic       in_gap;
  logic [3:0] com_nxt;
  logic [7:0] font_nxt;

  always_comb begin
    cur_dig = sh_dig[idx];

    // A non-zero digit (dash codes included) ends the leading-zero run.
    blank3 = sh_blank_en && (sh_dig[3] == 4'd0);
    blank2 = blank3 && (sh_dig[2] == 4'd0);
    blank1 = blank2 && (sh_dig[1] == 4'd0);

    cur_blank = 1'b0;
    case (idx)
      2'd3:    cur_blank = blank3;
      2'd2:    cur_blank = blank2;
      2'd1:    cur_blank = blank1;
      default: cur_blank = 1'b0;
    endcase

    seg = 7'h3F;
    case (cur_dig)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase

    in_gap = int'(cnt) < BLANK_CYC;

    com_nxt  = 4'hF;
    font_nxt = 8'hFF;
    if (!in_gap) begin
      com_nxt  = ~(4'd1 << idx);
      font_nxt = {~sh_dp[idx], cur_blank ? 7'h7F : seg};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_fnd_com    <= 4'hF;
      bus.o_fnd_font   <= 8'hFF;
      bus.o_frame_tick <= 1'b0;
    end else begin
      bus.o_fnd_com    <= com_nxt;
      bus.o_fnd_font   <= font_nxt;
      bus.o_frame_tick <= load;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Random-stimulus bench for fnd_scan_driver: one instance with an anti-ghost gap, one without.
// Expected outputs come from a frame-level model (cycle position, latched digit set, lookup table).
module tb_fnd_scan_driver;

  localparam int SD  = 8;
  localparam int FRM = 4 * SD;
  localparam int BC0 = 2;
  localparam int BC1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_driver_if bus_g ();
  fnd_scan_driver_if bus_n ();

  fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC0)) dut_gap (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_g));
  fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC1)) dut_nogap (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_n));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus, mirrored onto both instances.
  logic [3:0] in_dig [4];
  logic [3:0] in_dp;
  logic       in_ben;

  always_comb begin
    bus_g.i_digit1 = in_dig[0]; bus_g.i_digit10 = in_dig[1];
    bus_g.i_digit100 = in_dig[2]; bus_g.i_digit1000 = in_dig[3];
    bus_g.i_dp = in_dp; bus_g.i_blank_en = in_ben;
    bus_n.i_digit1 = in_dig[0]; bus_n.i_digit10 = in_dig[1];
    bus_n.i_digit100 = in_dig[2]; bus_n.i_digit1000 = in_dig[3];
    bus_n.i_dp = in_dp; bus_n.i_blank_en = in_ben;
  end

  // Model state: edges since reset release and the digit set currently on display.
  int         n;
  logic [3:0] m_dig [4];
  logic [3:0] m_dp;
  logic       m_ben;
  logic [3:0] e_com  [2];
  logic [7:0] e_font [2];
  logic       e_tick;

  function automatic logic [7:0] font_of(input int slot, input logic [3:0] d [4],
                                         input logic [3:0] dp, input logic ben);
    logic [6:0] tbl [16];
    bit lead;
    bit blanked;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h10 & 7'h00, 7'h10,
            7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    lead = ben;
    blanked = 1'b0;
    for (int k = 3; k >= slot; k--) begin
      lead = lead && (d[k] == 4'd0) && (k != 0);
      if (k == slot) blanked = lead;
    end
    return {~dp[slot], blanked ? 7'h7F : tbl[d[slot]]};
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
    m_dp = 4'd0;
    m_ben = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_com_g"},  {4'h0, bus_g.o_fnd_com}, 8'h0F);
    chk({tag, "_font_g"}, bus_g.o_fnd_font, 8'hFF);
    chk({tag, "_tick_g"}, {7'd0, bus_g.o_frame_tick}, 8'h00);
    chk({tag, "_com_n"},  {4'h0, bus_n.o_fnd_com}, 8'h0F);
    chk({tag, "_font_n"}, bus_n.o_fnd_font, 8'hFF);
  endtask

  // One clock: predict from the pre-edge position, then compare half a cycle later.
  task automatic cycle();
    int p;
    int slot;
    int bcs [2];
    bcs[0] = BC0;
    bcs[1] = BC1;
    @(posedge clk);
    n++;
    p = (n - 1) % FRM;
    slot = p / SD;
    for (int i = 0; i < 2; i++) begin
      if ((p % SD) < bcs[i]) begin
        e_com[i]  = 4'hF;
        e_font[i] = 8'hFF;
      end else begin
        e_com[i]  = ~(4'd1 << slot);
        e_font[i] = font_of(slot, m_dig, m_dp, m_ben);
      end
    end
    e_tick = (p == FRM - 1);
    if (e_tick) begin
      for (int k = 0; k < 4; k++) m_dig[k] = in_dig[k];
      m_dp = in_dp;
      m_ben = in_ben;
    end
    @(negedge clk);
    chk("com_g",  {4'h0, bus_g.o_fnd_com}, {4'h0, e_com[0]});
    chk("font_g", bus_g.o_fnd_font, e_font[0]);
    chk("tick_g", {7'd0, bus_g.o_frame_tick}, {7'd0, e_tick});
    chk("com_n",  {4'h0, bus_n.o_fnd_com}, {4'h0, e_com[1]});
    chk("font_n", bus_n.o_fnd_font, e_font[1]);
    chk("tick_n", {7'd0, bus_n.o_frame_tick}, {7'd0, e_tick});
  endtask

  function automatic logic [3:0] rand_digit();
    int r;
    r = $urandom_range(0, 15);
    if (r < 5)  return 4'd0;
    if (r < 13) return 4'($urandom_range(1, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    in_dig = '{4'd4, 4'd3, 4'd2, 4'd1};
    in_dp  = 4'b0100;
    in_ben = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("in_reset");
    end
    rst_n = 1'b1;

    // Directed opening: first frame shows zeros, second shows 1234 with dp on hundreds.
    for (int c = 0; c < 2 * FRM; c++) begin
      cycle();
      if (n == 3)          chk("first_frame_slot0", bus_g.o_fnd_font, 8'hC0);
      if (n == 32)         chk("first_tick_33rd_cycle", {7'd0, bus_g.o_frame_tick}, 8'h01);
      if (n == 35)         chk("frame2_ones", bus_g.o_fnd_font, 8'h99);
      if (n == 35 + 2*SD)  chk("frame2_hund_dp", bus_g.o_fnd_font, 8'h24);
      if (n == 35 + 3*SD)  chk("frame2_thou", bus_g.o_fnd_font, 8'hF9);
    end

    // Leading-zero blanking and a dash stopping it.
    in_dig = '{4'd0, 4'd7, 4'd0, 4'd0};
    in_dp  = 4'b0000;
    in_ben = 1'b1;
    for (int c = 0; c < 2 * FRM; c++) cycle();
    in_dig = '{4'd0, 4'd0, 4'd0, 4'd0};
    for (int c = 0; c < 2 * FRM; c++) cycle();
    in_dig = '{4'd5, 4'd0, 4'd0, 4'hB};
    for (int c = 0; c < 2 * FRM; c++) cycle();

    // Random traffic with changes at arbitrary cycles, plus one mid-frame reset.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < 4; k++) in_dig[k] = rand_digit();
        in_dp  = 4'($urandom_range(0, 15));
        in_ben = ($urandom_range(0, 3) != 0);
      end
      cycle();
      if (c > 600 && c < 700 && (n % FRM) == (2 * SD + 5)) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        check_reset_vals("held_reset");
        rst_n = 1'b1;
        model_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
